// File: rtl/store_buf_ring_if.sv
// Handshake bundle between the rotating store-buffer controller and its
// fill engine / read datapath.
interface store_buf_ring_if #(
    parameter int NUM_BUF = 2,
    parameter int ID_W    = $clog2(NUM_BUF),
    parameter int SEQ_W   = 2
);
    logic               trigger;
    logic               fill_req;
    logic [ID_W-1:0]    fill_idx;
    logic [SEQ_W-1:0]   fill_seq;
    logic               fill_ack;
    logic               fill_done;
    logic [NUM_BUF-1:0] load;
    logic [ID_W-1:0]    choose;
    logic               rd_valid;
    logic               underrun;

    modport master (
        input  trigger, fill_ack, fill_done,
        output fill_req, fill_idx, fill_seq, load, choose, rd_valid, underrun
    );

    modport slave (
        output trigger, fill_ack, fill_done,
        input  fill_req, fill_idx, fill_seq, load, choose, rd_valid, underrun
    );
endinterface

// File: rtl/store_buf_ring_ctrl.sv
// N-way rotating store-buffer controller: dispatches fills to one fill engine
// and rotates the read side through the buffers on each trigger.
module store_buf_ring_ctrl #(
    parameter int NUM_BUF = 2,
    parameter int ID_W    = $clog2(NUM_BUF),
    parameter int SEQ_W   = 2
) (
    input logic              clk,
    input logic              rst,
    store_buf_ring_if.master bus
);
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_ACTIVE} buf_st_e;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_BUSY} fill_st_e;

    buf_st_e            r_buf     [NUM_BUF];
    buf_st_e            w_buf_nxt [NUM_BUF];
    fill_st_e           r_fill_st, w_fill_st_nxt;
    logic [ID_W-1:0]    r_active, w_active_nxt, w_next_act;
    logic [ID_W-1:0]    r_fill_idx, w_fill_idx_nxt, w_pick;
    logic [SEQ_W-1:0]   r_fill_seq, w_fill_seq_nxt;
    logic               r_fill_req, w_fill_req_nxt;
    logic               r_rd_valid, w_rd_valid_nxt;
    logic               r_underrun, w_underrun_nxt;
    logic [NUM_BUF-1:0] r_load, w_load_nxt;
    logic               w_found, w_accept, w_done_hit;

    function automatic logic [ID_W-1:0] f_wrap_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(NUM_BUF - 1)) ? '0 : i + ID_W'(1);
    endfunction

    // A buffer counts as ready if it is FULL or its fill completes this cycle.
    function automatic logic f_ready(input buf_st_e st, input logic done_here);
        return (st == B_FULL) || ((st == B_FILLING) && done_here);
    endfunction

    assign w_accept   = (r_fill_st == F_REQ)  && bus.fill_ack;
    assign w_done_hit = (r_fill_st == F_BUSY) && bus.fill_done;

    // First EMPTY buffer scanning from the active one; descending loop so the
    // smallest offset is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_BUF - 1; k >= 0; k--) begin
            int c;
            c = (int'(r_active) + k) % NUM_BUF;
            if (r_buf[c] == B_EMPTY) begin
                w_found = 1'b1;
                w_pick  = ID_W'(c);
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_fill_st_nxt = r_fill_st;
        unique case (r_fill_st)
            F_IDLE:  if (w_found)    w_fill_st_nxt = F_REQ;
            F_REQ:   if (w_accept)   w_fill_st_nxt = F_BUSY;
            F_BUSY:  if (w_done_hit) w_fill_st_nxt = F_IDLE;
            default:                 w_fill_st_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        w_buf_nxt      = r_buf;
        w_active_nxt   = r_active;
        w_rd_valid_nxt = r_rd_valid;
        w_underrun_nxt = r_underrun;
        w_fill_req_nxt = (w_fill_st_nxt == F_REQ);
        w_fill_idx_nxt = r_fill_idx;
        w_fill_seq_nxt = r_fill_seq;
        w_next_act     = f_wrap_inc(r_active);
        w_load_nxt     = '0;

        if ((r_fill_st == F_IDLE) && w_found) w_fill_idx_nxt = w_pick;
        if (w_accept) begin
            w_buf_nxt[r_fill_idx] = B_FILLING;
            w_fill_seq_nxt        = r_fill_seq + SEQ_W'(1);
        end
        if (w_done_hit) w_buf_nxt[r_fill_idx] = B_FULL;

        // Read side is applied last so a same-cycle fill completion bypasses to ACTIVE.
        if (r_rd_valid && bus.trigger) begin
            w_buf_nxt[r_active] = B_EMPTY;
            w_active_nxt        = w_next_act;
            if (f_ready(r_buf[w_next_act], w_done_hit && (r_fill_idx == w_next_act))) begin
                w_buf_nxt[w_next_act] = B_ACTIVE;
            end else begin
                w_rd_valid_nxt = 1'b0;
                w_underrun_nxt = 1'b1;
            end
        end else if (!r_rd_valid &&
                     f_ready(r_buf[r_active], w_done_hit && (r_fill_idx == r_active))) begin
            w_buf_nxt[r_active] = B_ACTIVE;
            w_rd_valid_nxt      = 1'b1;
            w_underrun_nxt      = 1'b0;
        end

        for (int i = 0; i < NUM_BUF; i++) w_load_nxt[i] = (w_buf_nxt[i] == B_FILLING);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fill_st <= F_IDLE;
        else     r_fill_st <= w_fill_st_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUF; i++) r_buf[i] <= B_EMPTY;
            r_active   <= '0;
            r_rd_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_fill_req <= 1'b0;
            r_fill_idx <= '0;
            r_fill_seq <= '0;
            r_load     <= '0;
        end else begin
            r_buf      <= w_buf_nxt;
            r_active   <= w_active_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_underrun <= w_underrun_nxt;
            r_fill_req <= w_fill_req_nxt;
            r_fill_idx <= w_fill_idx_nxt;
            r_fill_seq <= w_fill_seq_nxt;
            r_load     <= w_load_nxt;
        end
    end

    assign bus.fill_req = r_fill_req;
    assign bus.fill_idx = r_fill_idx;
    assign bus.fill_seq = r_fill_seq;
    assign bus.load     = r_load;
    assign bus.choose   = r_active;
    assign bus.rd_valid = r_rd_valid;
    assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_store_buf_ring_ctrl.sv
// Self-checking bench for store_buf_ring_ctrl (4 buffers): directed scenarios
// plus random traffic, compared every cycle against a behavioural model.
module tb_store_buf_ring_ctrl;
    localparam int NB = 4;
    localparam int SW = 2;
    localparam int EMPTY = 0, FILLING = 1, FULL = 2, ACT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Model: per-buffer state, read pointer, and the single fill slot (0 idle, 1 requesting, 2 busy).
    int m_st [NB];
    int m_act, m_phase, m_idx, m_seq;
    bit m_valid, m_under;

    store_buf_ring_if #(.NUM_BUF(NB), .SEQ_W(SW)) bus ();
    store_buf_ring_ctrl #(.NUM_BUF(NB), .SEQ_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_st[i]) m_st[i] = EMPTY;
        m_act = 0; m_phase = 0; m_idx = 0; m_seq = 0;
        m_valid = 1'b0; m_under = 1'b0;
    endtask

    task automatic compare_all();
        check("fill_req", 32'(bus.fill_req), 32'(m_phase == 1));
        check("fill_idx", 32'(bus.fill_idx), m_idx);
        check("fill_seq", 32'(bus.fill_seq), m_seq);
        check("load",     32'(bus.load),     (m_phase == 2) ? (1 << m_idx) : 0);
        check("choose",   32'(bus.choose),   m_act);
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("underrun", 32'(bus.underrun), 32'(m_under));
    endtask

    task automatic model_step(input bit t, input bit a, input bit d);
        bit acc, fin;
        int pick;
        acc  = (m_phase == 1) && a;
        fin  = (m_phase == 2) && d;
        pick = -1;
        if (m_phase == 0)
            for (int k = 0; k < NB; k++)
                if (pick < 0 && m_st[(m_act + k) % NB] == EMPTY) pick = (m_act + k) % NB;
        if (pick >= 0) begin m_phase = 1; m_idx = pick; end
        if (acc) begin m_st[m_idx] = FILLING; m_seq = (m_seq + 1) % (1 << SW); m_phase = 2; end
        if (fin) begin m_st[m_idx] = FULL; m_phase = 0; end
        if (m_valid && t) begin
            m_st[m_act] = EMPTY;
            m_act = (m_act + 1) % NB;
            if (m_st[m_act] == FULL) m_st[m_act] = ACT;
            else begin m_valid = 1'b0; m_under = 1'b1; end
        end else if (!m_valid && m_st[m_act] == FULL) begin
            m_st[m_act] = ACT; m_valid = 1'b1; m_under = 1'b0;
        end
    endtask

    task automatic step(input bit t, input bit a, input bit d);
        @(negedge clk);
        compare_all();
        bus.trigger = t; bus.fill_ack = a; bus.fill_done = d;
        model_step(t, a, d);
    endtask

    task automatic auto_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, m_phase == 1, m_phase == 2);
    endtask

    initial begin
        bit reached;
        bus.trigger = 1'b0; bus.fill_ack = 1'b0; bus.fill_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);

        // Bring-up: fills 0,1,2,3 in order, buffer 0 becomes readable.
        auto_steps(20);

        // Rotation through all buffers with refills in freed order.
        for (int r = 0; r < 4; r++) begin
            step(1'b1, m_phase == 1, m_phase == 2);
            auto_steps(5);
        end

        // Underrun: keep fills from completing while the reader races ahead.
        for (int r = 0; r < 4; r++) step(1'b1, m_phase == 1, 1'b0);
        repeat (5) step(1'b0, m_phase == 1, 1'b0);
        auto_steps(12);

        // Request held without acknowledge; a stray done must be ignored.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i == 4);
        auto_steps(8);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30);

        // Asynchronous reset while buffer 2 is filling.
        @(negedge clk);
        rst = 1'b1;
        bus.trigger = 1'b0; bus.fill_ack = 1'b0; bus.fill_done = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step(1'b0, m_phase == 1, (m_phase == 2) && (m_idx != 2));
            reached = (m_phase == 2) && (m_idx == 2);
        end
        check("reach_busy_buf2", 32'(reached), 1);
        @(negedge clk);
        compare_all();
        #2 rst = 1'b1;
        #1;
        check("arst_fill_req", 32'(bus.fill_req), 0);
        check("arst_fill_idx", 32'(bus.fill_idx), 0);
        check("arst_fill_seq", 32'(bus.fill_seq), 0);
        check("arst_load",     32'(bus.load),     0);
        check("arst_choose",   32'(bus.choose),   0);
        check("arst_rd_valid", 32'(bus.rd_valid), 0);
        check("arst_underrun", 32'(bus.underrun), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        auto_steps(6);
        @(negedge clk);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
